// File: rtl/uart_cmd_assembler.sv
// Frames UART bytes into 16-bit commands (high byte first) with an inter-byte timeout,
// and forwards single response bytes from the command processor to the UART transmitter.
module uart_cmd_assembler #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        timeout_err
);

    // A one-cycle timeout still needs a 1-bit timer.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {RX_HIGH, RX_LOW} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    rx_state_t      rx_state_q, rx_state_d;
    logic [7:0]     high_byte_q, high_byte_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    cmd_q, cmd_d;
    logic           cmd_rdy_q, cmd_rdy_d;
    logic           timeout_err_q, timeout_err_d;

    tx_state_t      tx_state_q, tx_state_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           trmt_q, trmt_d;
    logic           resp_sent_q, resp_sent_d;

    logic           capture_high;
    logic           complete_cmd;

    // Every presented byte is consumed immediately, in either RX state.
    assign clr_rx_rdy   = rx_rdy & rst_n;
    assign capture_high = (rx_state_q == RX_HIGH) & rx_rdy;
    assign complete_cmd = (rx_state_q == RX_LOW) & rx_rdy;

    always_comb begin
        rx_state_d    = rx_state_q;
        high_byte_d   = high_byte_q;
        timer_d       = timer_q;
        cmd_d         = cmd_q;
        timeout_err_d = 1'b0;
        case (rx_state_q)
            RX_HIGH: begin
                if (rx_rdy) begin
                    high_byte_d = rx_data;
                    timer_d     = '0;
                    rx_state_d  = RX_LOW;
                end
            end
            RX_LOW: begin
                if (rx_rdy) begin
                    cmd_d      = {high_byte_q, rx_data};
                    rx_state_d = RX_HIGH;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    high_byte_d   = '0;
                    timer_d       = '0;
                    rx_state_d    = RX_HIGH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: rx_state_d = RX_HIGH;
        endcase
    end

    // Set has priority over both clear sources.
    assign cmd_rdy_d = complete_cmd | (cmd_rdy_q & ~clr_cmd_rdy & ~capture_high);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = resp_sent_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (send_resp) begin
                    tx_data_d   = resp;
                    trmt_d      = 1'b1;
                    resp_sent_d = 1'b0;
                    tx_state_d  = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    tx_state_d  = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q    <= RX_HIGH;
            high_byte_q   <= '0;
            timer_q       <= '0;
            cmd_q         <= '0;
            cmd_rdy_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_data_q     <= '0;
            trmt_q        <= 1'b0;
            resp_sent_q   <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            high_byte_q   <= high_byte_d;
            timer_q       <= timer_d;
            cmd_q         <= cmd_d;
            cmd_rdy_q     <= cmd_rdy_d;
            timeout_err_q <= timeout_err_d;
            tx_state_q    <= tx_state_d;
            tx_data_q     <= tx_data_d;
            trmt_q        <= trmt_d;
            resp_sent_q   <= resp_sent_d;
        end
    end

    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign timeout_err = timeout_err_q;
    assign tx_data     = tx_data_q;
    assign trmt        = trmt_q;
    assign resp_sent   = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios, then random traffic checked each
// cycle against a transaction-level model of the framer and responder.
module tb_uart_cmd_assembler;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        resp_sent;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_cmd_assembler #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .resp_sent(resp_sent), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending bytes of a partial command, time of high-byte capture,
    // and the expected state of every registered output after the next edge.
    logic [7:0]  pend_q[$];
    int          cap_cyc;
    int          cyc;
    logic [15:0] m_cmd;
    logic        m_cmd_rdy, m_timeout, m_trmt, m_resp_sent, m_tx_busy;
    logic [7:0]  m_tx_data;
    int          done_wait;
    int          trmt_cnt, to_cnt;

    task automatic model_reset();
        pend_q.delete();
        cap_cyc     = 0;
        cyc         = 0;
        m_cmd       = '0;
        m_cmd_rdy   = 1'b0;
        m_timeout   = 1'b0;
        m_trmt      = 1'b0;
        m_resp_sent = 1'b0;
        m_tx_busy   = 1'b0;
        m_tx_data   = '0;
        done_wait   = 0;
    endtask

    task automatic compare_outputs();
        check("cmd", cmd, m_cmd);
        check("cmd_rdy", cmd_rdy, m_cmd_rdy);
        check("timeout_err", timeout_err, m_timeout);
        check("tx_data", tx_data, m_tx_data);
        check("trmt", trmt, m_trmt);
        check("resp_sent", resp_sent, m_resp_sent);
        if (trmt) trmt_cnt++;
        if (timeout_err) to_cnt++;
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic step(input logic rv, input logic [7:0] rb, input logic ccr,
                        input logic sr, input logic [7:0] rp);
        logic done_v;
        logic completed;
        logic captured;
        compare_outputs();
        done_v = (done_wait == 1);
        if (done_wait > 0) done_wait--;
        rx_rdy      = rv;
        rx_data     = rb;
        clr_cmd_rdy = ccr;
        send_resp   = sr;
        resp        = rp;
        tx_done     = done_v;
        #1;
        check("clr_rx_rdy", clr_rx_rdy, rv);

        completed = 1'b0;
        captured  = 1'b0;
        m_timeout = 1'b0;
        if (rv) begin
            pend_q.push_back(rb);
            if (pend_q.size() == 1) begin
                captured = 1'b1;
                cap_cyc  = cyc;
            end else begin
                m_cmd = {pend_q[0], pend_q[1]};
                pend_q.delete();
                completed = 1'b1;
            end
        end else if (pend_q.size() == 1 && (cyc - cap_cyc) == T) begin
            m_timeout = 1'b1;
            pend_q.delete();
        end
        if (completed) m_cmd_rdy = 1'b1;
        else if (captured || ccr) m_cmd_rdy = 1'b0;

        m_trmt = 1'b0;
        if (!m_tx_busy) begin
            if (sr) begin
                m_tx_busy   = 1'b1;
                m_tx_data   = rp;
                m_trmt      = 1'b1;
                m_resp_sent = 1'b0;
                done_wait   = $urandom_range(2, 12);
            end
        end else if (done_v) begin
            m_tx_busy   = 1'b0;
            m_resp_sent = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    endtask

    // Asserted at a falling edge so the check shows outputs clear without a rising edge.
    task automatic do_reset();
        rst_n       = 1'b0;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
        #1;
        check("rst_clr_rx_rdy", clr_rx_rdy, 1'b0);
        model_reset();
        compare_outputs();
        rx_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        logic rv, ccr, sr;
        rst_n       = 1'b0;
        rx_data     = '0;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        resp        = '0;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
        trmt_cnt    = 0;
        to_cnt      = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        idle(19);
        step(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
        check("cmd_a53c", cmd, 16'hA53C);
        check("cmd_rdy_a53c", cmd_rdy, 1'b1);

        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
        check("stale_cmd_rdy_cleared", cmd_rdy, 1'b0);
        idle(3);
        step(1'b1, 8'h34, 1'b1, 1'b0, 8'h00);
        check("set_wins_cmd_rdy", cmd_rdy, 1'b1);
        check("cmd_1234", cmd, 16'h1234);

        to_cnt = 0;
        step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
        idle(T + 20);
        check("timeout_once", to_cnt, 1);
        check("cmd_kept_after_timeout", cmd, 16'h1234);
        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
        idle(1);
        step(1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
        check("cmd_0102", cmd, 16'h0102);

        trmt_cnt = 0;
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5);
        check("trmt_a5", trmt, 1'b1);
        check("tx_data_a5", tx_data, 8'hA5);
        check("resp_sent_low", resp_sent, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h11);
        check("busy_ignores_send", tx_data, 8'hA5);
        idle(20);
        check("resp_sent_high", resp_sent, 1'b1);
        check("single_trmt", trmt_cnt, 1);

        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
        idle(2);
        do_reset();
        idle(1);
        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'h34, 1'b0, 1'b0, 8'h00);
        check("cmd_after_reset", cmd, 16'h1234);

        // Gaps cluster near the timeout so both sides of the boundary are exercised.
        gap = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (gap == 0) begin
                rv  = 1'b1;
                gap = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 15)
                                                 : $urandom_range(T - 5, T + 5);
            end else begin
                rv = 1'b0;
                gap--;
            end
            ccr = ($urandom_range(0, 7) == 0);
            sr  = ($urandom_range(0, 9) == 0);
            step(rv, 8'($urandom), ccr, sr, 8'($urandom));
        end
        compare_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
